seg7_capture: RTL and testbench

Receiving end of the 7-segment display interface: it watches the multiplexed, active-low segment bus and digit-anode lines driven by the display path and reconstructs the hexadecimal value being shown. Each digit pattern must be stable before it is decoded back to a nibble. Once every digit has been captured in a frame, it publishes the assembled word with a one-cycle valid pulse. It is used as a self-check and loopback monitor beside the display driver in the FSM practice designs.

---
 rtl/seg7_if.sv | 10 +
 rtl/seg7_capture.sv | 99 +++++++++
 tb/tb_seg7_capture.sv | 134 +++++++++++++
 3 files changed

// File: rtl/seg7_if.sv
// seg7_if: multiplexed active-low 7-segment bus plus the reconstructed frame it carries
interface seg7_if #(parameter int DIGITS = 4);
    logic [0:6]          seg_in;
    logic [DIGITS-1:0]   an_in;
    logic [4*DIGITS-1:0] value_out;
    logic                frame_valid;
    logic                frame_err;
    modport master (output seg_in, an_in, input value_out, frame_valid, frame_err);
    modport slave (input seg_in, an_in, output value_out, frame_valid, frame_err);
endinterface

// File: rtl/seg7_capture.sv
// seg7_capture: rebuilds the hex word shown on a multiplexed active-low 7-segment display
module seg7_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input logic   clk,
    input logic   rst,
    seg7_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
    state_t              state;
    logic [0:6]          s_seg, p_seg;
    logic [DIGITS-1:0]   s_an, p_an, seen, err, hit, seen_n, err_n;
    logic [CW-1:0]       cnt;
    logic [4*DIGITS-1:0] shadow, shadow_n;
    logic [IW-1:0]       idx;
    logic                onehot, changed, ok;
    logic [3:0]          nib;
    function automatic logic [4:0] decode(input logic [0:6] p);
        case (p)
            7'h01:   decode = 5'h10;
            7'h4F:   decode = 5'h11;
            7'h12:   decode = 5'h12;
            7'h06:   decode = 5'h13;
            7'h4C:   decode = 5'h14;
            7'h24:   decode = 5'h15;
            7'h20:   decode = 5'h16;
            7'h0F:   decode = 5'h17;
            7'h00:   decode = 5'h18;
            7'h0C:   decode = 5'h19;
            7'h08:   decode = 5'h1A;
            7'h60:   decode = 5'h1B;
            7'h31:   decode = 5'h1C;
            7'h42:   decode = 5'h1D;
            7'h30:   decode = 5'h1E;
            7'h38:   decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction
    // decode the current sample and precompute the shadow/seen/err update for a capture
    always_comb begin
        hit = ~s_an;
        onehot = hit != '0 && (hit & (hit - DIGITS'(1))) == '0;
        idx = '0;
        for (int i = 0; i < DIGITS; i++) if (hit[i]) idx = IW'(i);
        {ok, nib} = decode(s_seg);
        changed = s_seg != p_seg || s_an != p_an;
        seen_n = seen | hit;
        err_n = ok ? err & ~hit : err | hit;
        shadow_n = shadow;
        shadow_n[4*idx +: 4] = nib;
    end
    // sample the bus, track stability, capture digits and publish completed frames
    always_ff @(posedge clk) begin
        if (rst) begin
            s_seg           <= '1;
            s_an            <= '1;
            p_seg           <= '1;
            p_an            <= '1;
            cnt             <= '0;
            state           <= IDLE;
            seen            <= '0;
            err             <= '0;
            shadow          <= '0;
            bus.value_out   <= '0;
            bus.frame_valid <= 1'b0;
            bus.frame_err   <= 1'b0;
        end else begin
            s_seg           <= bus.seg_in;
            s_an            <= bus.an_in;
            bus.frame_valid <= 1'b0;
            if (changed) begin
                p_seg <= s_seg;
                p_an  <= s_an;
                cnt   <= '0;
                state <= onehot ? SETTLE : IDLE;
            end else if (state == SETTLE) begin
                if (cnt == CW'(STABLE_CYCLES - 2)) begin
                    state  <= HELD;
                    shadow <= shadow_n;
                    if (&seen_n) begin
                        bus.value_out   <= shadow_n;
                        bus.frame_err   <= |err_n;
                        bus.frame_valid <= 1'b1;
                        seen            <= '0;
                        err             <= '0;
                    end else begin
                        seen <= seen_n;
                        err  <= err_n;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed scans with a frame scoreboard checked against seg7_capture
module tb_seg7_capture;
    localparam int D = 4;
    localparam int ST = 4;
    localparam logic [6:0] TBL [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                        7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    typedef struct {
        int          cyc;
        logic [15:0] v;
        logic        e;
    } exp_t;
    logic clk = 0;
    logic rst = 1;
    int cyc = 0;
    int npass = 0;
    int ntot = 0;
    exp_t q[$];
    logic [15:0] shadow_m = 0;
    logic [3:0] seen_m = 0, err_m = 0;
    logic [15:0] last_v = 0;
    logic last_e = 0;
    seg7_if #(.DIGITS(D)) bus ();
    seg7_capture #(.DIGITS(D), .STABLE_CYCLES(ST)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // cycle counter used to time-stamp expected frames
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask
    // model: a pattern shown for at least ST sampled cycles on one anode is captured
    task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
        int idx;
        logic ok;
        logic [3:0] nib;
        bus.an_in = an;
        bus.seg_in = seg;
        if (n >= ST && $countones(~an) == 1) begin
            idx = 0;
            for (int i = 0; i < D; i++) if (!an[i]) idx = i;
            ok = 0;
            nib = 0;
            for (int i = 0; i < 16; i++) if (TBL[i] == seg) begin ok = 1; nib = 4'(i); end
            shadow_m[4*idx +: 4] = nib;
            seen_m[idx] = 1;
            err_m[idx] = !ok;
            if (&seen_m) begin
                q.push_back('{cyc + 1 + ST, shadow_m, |err_m});
                seen_m = 0;
                err_m = 0;
            end
        end
        repeat (n) @(negedge clk);
    endtask
    task automatic do_reset();
        rst = 1;
        bus.an_in = 4'($urandom);
        bus.seg_in = 7'($urandom);
        shadow_m = 0;
        seen_m = 0;
        err_m = 0;
        last_v = 0;
        last_e = 0;
        q.delete();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask
    task automatic scan(input logic [6:0] s0, s1, s2, s3);
        show(4'b1110, s0, 8);
        show(4'b1101, s1, 8);
        show(4'b1011, s2, 8);
        show(4'b0111, s3, 8);
        show(4'b1111, 7'h7F, 3);
    endtask
    // scoreboard: each pulse pops one expected frame; between pulses outputs must hold
    always @(negedge clk) begin
        exp_t x;
        if (!rst) begin
            if (bus.frame_valid) begin
                if (q.size() == 0) begin
                    check("spurious_pulse", 32'(bus.frame_valid), 0);
                end else begin
                    x = q.pop_front();
                    check("pulse_cycle", cyc, x.cyc);
                    check("value_out", 32'(bus.value_out), 32'(x.v));
                    check("frame_err", 32'(bus.frame_err), 32'(x.e));
                    last_v = x.v;
                    last_e = x.e;
                end
            end else begin
                check("hold_value", 32'(bus.value_out), 32'(last_v));
                check("hold_err", 32'(bus.frame_err), 32'(last_e));
            end
        end
    end
    initial begin
        bus.an_in = '1;
        bus.seg_in = '1;
        @(negedge clk);
        do_reset();
        check("rst_value", 32'(bus.value_out), 0);
        check("rst_valid", 32'(bus.frame_valid), 0);
        check("rst_err", 32'(bus.frame_err), 0);
        show(4'b1110, 7'h12, 3);
        show(4'b1111, 7'h7F, 3);
        scan(7'h12, 7'h06, 7'h4C, 7'h24);
        show(4'b1110, 7'h01, 8);
        show(4'b1101, 7'h06, 3);
        show(4'b1101, 7'h0F, 8);
        show(4'b1011, 7'h01, 8);
        show(4'b0111, 7'h01, 8);
        show(4'b1111, 7'h7F, 3);
        scan(7'h4F, 7'h4F, 7'h7F, 7'h4F);
        scan(7'h12, 7'h4F, 7'h08, 7'h60);
        show(4'b1110, 7'h31, 8);
        show(4'b1101, 7'h42, 8);
        show(4'b1100, 7'h30, 20);
        show(4'b1011, 7'h30, 8);
        show(4'b0111, 7'h38, 8);
        show(4'b1111, 7'h7F, 3);
        show(4'b1110, 7'h0C, 8);
        show(4'b1101, 7'h00, 8);
        do_reset();
        show(4'b1011, 7'h0C, 8);
        show(4'b0111, 7'h00, 8);
        show(4'b1111, 7'h7F, 10);
        scan(7'h20, 7'h0F, 7'h0C, 7'h00);
        repeat (10) @(negedge clk);
        check("pending_frames", q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
